obi_rr_arbiter: RTL

- Parametrised N-master to 1-slave OBI arbiter for the core testbench. Merges core instruction, core data and debug system-bus masters onto one memory port, replacing the fixed-priority instr/data/sb muxing.
- Adds round-robin fairness, a configurable number of outstanding transactions and in-order response routing.
- Adds a sticky protocol-error flag that the bench monitors.

---
 rtl/obi_rr_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: N-master to 1-slave OBI arbiter with round-robin or fixed priority and in-order response routing.
//   clk_i/rst_i                  clock, synchronous active-high reset
//   m_req_i/m_gnt_o/m_addr_i/m_we_i/m_be_i/m_wdata_i   packed master request channels
//   m_rvalid_o/m_rdata_o/m_err_o one-hot response valid, shared read data and error
//   s_*                          single slave port
//   outstanding_o                registered response-FIFO occupancy
//   protocol_err_o               sticky flag for a response with nothing outstanding
module obi_rr_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIXED_PRIO      = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_req_i,
    output logic [NUM_MASTERS-1:0]                m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NUM_MASTERS-1:0]                m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic                                  m_err_o,
    output logic                                  s_req_o,
    input  logic                                  s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic                                  s_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_be_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic                                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    input  logic                                  s_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  protocol_err_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = $clog2(NUM_MASTERS);
    localparam int FW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [PW-1:0] rr_ptr, base, win, head;
    logic [PW-1:0] fifo [MAX_OUTSTANDING];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          found, full, accept, pop;
    int            idx;

    assign base = FIXED_PRIO != 0 ? '0 : rr_ptr;

    // Scan from base upward with wrap; the first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_req_i[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    // A full FIFO blocks requests even when a pop lands in the same cycle.
    assign full      = count == CW'(MAX_OUTSTANDING);
    assign s_req_o   = found && !full && !rst_i;
    assign accept    = s_req_o && s_gnt_i;
    assign s_addr_o  = found ? m_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_we_o    = found && m_we_i[win];
    assign s_be_o    = found ? m_be_i[win*BW +: BW] : '0;
    assign s_wdata_o = found ? m_wdata_i[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_gnt_o   = accept ? NUM_MASTERS'(1) << win : '0;

    assign pop        = s_rvalid_i && count != '0 && !rst_i;
    assign head       = fifo[rd_ptr];
    assign m_rvalid_o = pop ? NUM_MASTERS'(1) << head : '0;
    assign m_rdata_o  = s_rdata_i;
    assign m_err_o    = s_err_i;

    assign outstanding_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr == FW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
                if (FIXED_PRIO == 0) rr_ptr <= win == PW'(NUM_MASTERS - 1) ? '0 : win + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == FW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
            if (s_rvalid_i && count == '0) protocol_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) fifo[wr_ptr] <= win;
    end
endmodule
